qlm_mult_pipe: RTL

//  Parametrised, pipelined successor to the 16-bit registered QLM multiplier wrapper.

---
 rtl/qlm_pkg.sv | 21 ++
 rtl/qlm_log_core.sv | 52 +++++
 rtl/qlm_mult_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/qlm_pkg.sv
// rtl/qlm_pkg.sv - shared QLM mode encodings and leading-one detect helper
package qlm_pkg;

    localparam logic QLM_EXACT  = 1'b0;
    localparam logic QLM_APPROX = 1'b1;

    localparam int LOD_MAX_W = 64;

    // Index of the most significant set bit; 0 for a zero operand.
    function automatic logic [6:0] lod(input logic [LOD_MAX_W-1:0] a);
        logic [6:0] idx;
        idx = '0;
        for (int i = 0; i < LOD_MAX_W; i++) begin
            if (a[i]) begin
                idx = 7'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/qlm_log_core.sv
// rtl/qlm_log_core.sv - combinational Mitchell log-add and antilog halves
module qlm_log_core #(
    parameter int W      = 16,
    parameter int FRAC_W = 6
) (
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    input  logic [$clog2(W)-1:0]  ka,
    input  logic [$clog2(W)-1:0]  kb,
    output logic [FRAC_W:0]       s_sum,
    output logic [$clog2(W):0]    k_sum,
    output logic                  zero,
    input  logic [FRAC_W:0]       al_s,
    input  logic [$clog2(W):0]    al_k,
    output logic [2*W-1:0]        al_p
);

    localparam int KW  = $clog2(W);
    localparam int KSW = KW + 1;
    localparam int PW  = 2 * W;
    localparam int AW  = 2 * W + FRAC_W + 2;

    logic [W-1:0]      a_frac;
    logic [W-1:0]      b_frac;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    logic [KSW-1:0]    k_inc;
    logic [AW-1:0]     mant;

    // Fraction below the leading one, left-aligned to FRAC_W bits with truncation.
    always_comb begin
        a_frac = a & ~(W'(1) << ka);
        b_frac = b & ~(W'(1) << kb);
        fa     = FRAC_W'({a_frac, {FRAC_W{1'b0}}} >> ka);
        fb     = FRAC_W'({b_frac, {FRAC_W{1'b0}}} >> kb);
        s_sum  = {1'b0, fa} + {1'b0, fb};
        k_sum  = KSW'(ka) + KSW'(kb);
        zero   = (a == '0) || (b == '0);
    end

    // A carry out of the fraction sum bumps the characteristic by one.
    always_comb begin
        k_inc = al_k + KSW'(1);
        if (al_s[FRAC_W]) begin
            mant = AW'(al_s) << k_inc;
        end else begin
            mant = AW'({1'b1, al_s[FRAC_W-1:0]}) << al_k;
        end
        al_p = PW'(mant >> FRAC_W);
    end

endmodule

// File: rtl/qlm_mult_pipe.sv
// rtl/qlm_mult_pipe.sv - pipelined exact/Mitchell multiplier with valid/ready and tag
module qlm_mult_pipe
    import qlm_pkg::*;
#(
    parameter int W      = 16,
    parameter int FRAC_W = 6,
    parameter int STAGES = 3,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p_out,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag
);

    localparam int KW  = $clog2(W);
    localparam int KSW = KW + 1;
    localparam int PW  = 2 * W;
    localparam int D   = STAGES - 2;
    localparam int MW  = 3 + TAG_W + PW + (FRAC_W + 1) + KSW + 1;

    if (W < 4 || W > LOD_MAX_W) begin : g_bad_w
        $error("qlm_mult_pipe: W out of range");
    end
    if (FRAC_W < 1 || FRAC_W > W - 1) begin : g_bad_frac
        $error("qlm_mult_pipe: FRAC_W out of range");
    end
    if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
        $error("qlm_mult_pipe: STAGES out of range");
    end
    if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
        $error("qlm_mult_pipe: SIGNED must be 0 or 1");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("qlm_mult_pipe: TAG_W must be at least 1");
    end

    logic adv;

    logic             v1_q, v1_d;
    logic             mode1_q, mode1_d;
    logic             neg1_q, neg1_d;
    logic [W-1:0]     a1_q, a1_d;
    logic [W-1:0]     b1_q, b1_d;
    logic [KW-1:0]    ka1_q, ka1_d;
    logic [KW-1:0]    kb1_q, kb1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic [W-1:0]     x_mag;
    logic [W-1:0]     y_mag;

    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    p_out_q, p_out_d;
    logic             out_mode_q, out_mode_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Whole pipe moves as one unit; a held output freezes every stage.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Stage 1: capture, magnitude and leading-one detect.
    always_comb begin
        x_mag   = ((SIGNED != 0) && x[W-1]) ? (~x + W'(1)) : x;
        y_mag   = ((SIGNED != 0) && y[W-1]) ? (~y + W'(1)) : y;
        v1_d    = v1_q;
        mode1_d = mode1_q;
        neg1_d  = neg1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        ka1_d   = ka1_q;
        kb1_d   = kb1_q;
        tag1_d  = tag1_q;
        if (adv) begin
            v1_d    = in_valid;
            mode1_d = in_mode;
            neg1_d  = (SIGNED != 0) && (x[W-1] ^ y[W-1]);
            a1_d    = x_mag;
            b1_d    = y_mag;
            ka1_d   = KW'(lod(LOD_MAX_W'(x_mag)));
            kb1_d   = KW'(lod(LOD_MAX_W'(y_mag)));
            tag1_d  = in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mode1_q <= 1'b0;
            neg1_q  <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            ka1_q   <= '0;
            kb1_q   <= '0;
            tag1_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            neg1_q  <= neg1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            ka1_q   <= ka1_d;
            kb1_q   <= kb1_d;
            tag1_q  <= tag1_d;
        end
    end

    logic [PW-1:0]    m_prod;
    logic [FRAC_W:0]  m_s;
    logic [KSW-1:0]   m_k;
    logic             m_zero;
    logic [MW-1:0]    mid_pack;
    logic [MW-1:0]    mid_tail;

    logic             t_v;
    logic             t_mode;
    logic             t_neg;
    logic [TAG_W-1:0] t_tag;
    logic [PW-1:0]    t_prod;
    logic [FRAC_W:0]  t_s;
    logic [KSW-1:0]   t_k;
    logic             t_zero;
    logic [PW-1:0]    t_alp;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    res;

    qlm_log_core #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .a     (a1_q),
        .b     (b1_q),
        .ka    (ka1_q),
        .kb    (kb1_q),
        .s_sum (m_s),
        .k_sum (m_k),
        .zero  (m_zero),
        .al_s  (t_s),
        .al_k  (t_k),
        .al_p  (t_alp)
    );

    // Middle: both the exact product and the log sum are carried; mode picks at the end.
    assign m_prod   = PW'(a1_q) * PW'(b1_q);
    assign mid_pack = {v1_q, mode1_q, neg1_q, tag1_q, m_prod, m_s, m_k, m_zero};

    if (D == 0) begin : g_no_mid
        assign mid_tail = mid_pack;
    end else begin : g_mid
        logic [MW-1:0] mid_q [D];
        logic [MW-1:0] mid_d [D];

        always_comb begin
            for (int i = 0; i < D; i++) begin
                mid_d[i] = mid_q[i];
            end
            if (adv) begin
                mid_d[0] = mid_pack;
                for (int i = 1; i < D; i++) begin
                    mid_d[i] = mid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < D; i++) begin
                    mid_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < D; i++) begin
                    mid_q[i] <= mid_d[i];
                end
            end
        end

        assign mid_tail = mid_q[D-1];
    end

    assign {t_v, t_mode, t_neg, t_tag, t_prod, t_s, t_k, t_zero} = mid_tail;

    // Last stage: antilog select, sign apply (zero stays zero), output registers.
    always_comb begin
        mag         = (t_mode == QLM_APPROX) ? (t_zero ? '0 : t_alp) : t_prod;
        res         = (t_neg && (mag != '0)) ? (~mag + PW'(1)) : mag;
        out_valid_d = out_valid_q;
        p_out_d     = p_out_q;
        out_mode_d  = out_mode_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            out_valid_d = t_v;
            p_out_d     = res;
            out_mode_d  = t_mode;
            out_tag_d   = t_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            p_out_q     <= '0;
            out_mode_q  <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            p_out_q     <= p_out_d;
            out_mode_q  <= out_mode_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p_out     = p_out_q;
    assign out_mode  = out_mode_q;
    assign out_tag   = out_tag_q;

endmodule
